syscall_print_unit: RTL and testbench
=====================================

Name: syscall_print_unit

Overview:
- Requesting side of the data-memory print path.
- On a print-string syscall, walks a null-terminated byte string in data memory through a word-read port. Emits characters one at a time on a valid/ready stream to the console/trace sink.
- Asserts `busy` so the pipeline stalls until the string is fully emitted.
- Sits between the syscall decode in the EX/MEM stage and the unified memory's data read port.

Parameters:
- MEM_LO, 32'h00400000, lowest legal byte address (inclusive).
- MEM_HI, 32'h00420000, highest legal byte address (inclusive).
- MAX_LEN, 4096, maximum characters emitted before forced abort.
- CNT_W, 16, width of char_count; must be wide enough to hold MAX_LEN.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle request pulse to print the string at start_addr.
- start_addr, input, 32, byte address of the first character (syscall $a0).
- mem_addr, output, 32, word-aligned byte address for data-memory read.
- mem_read_data, input, 32, combinational read data for mem_addr, valid in the same cycle.
- char_out, output, 8, character being offered.
- char_valid, output, 1, char_out is valid.
- char_ready, input, 1, sink accepts char_out this cycle.
- busy, output, 1, high from the cycle after start is accepted until done; stalls the pipeline.
- done, output, 1, one-cycle pulse when the string ends, aborts, or faults.
- error, output, 1, sticky fault flag; cleared by the next accepted start.
- char_count, output, CNT_W, characters accepted by the sink for the current or last string.

Behaviour:
- Reset (async, any state): state=IDLE, mem_addr=0, char_out=0, char_valid=0, busy=0, done=0, error=0, char_count=0, internal cur_addr=0, word_buf=0.
- States: IDLE, FETCH, EMIT, FINISH.
- IDLE:
  - start=1: latch cur_addr=start_addr, clear char_count and error.
  - If start_addr==0, go to FINISH with no fetch and no output (null pointer prints nothing).
  - If start_addr<MEM_LO or >MEM_HI, set error and go to FINISH.
  - Otherwise go to FETCH.
  - start while not IDLE is ignored.
- FETCH (one cycle):
  - mem_addr={cur_addr[31:2],2'b00}.
  - word_buf<=mem_read_data at the clock edge; go to EMIT.
- EMIT:
  - byte select is little-endian on cur_addr[1:0]: 0->[7:0], 1->[15:8], 2->[23:16], 3->[31:24].
  - Selected byte==8'h00: char_valid=0, go to FINISH. The terminator is never emitted.
  - Else char_valid=1 and char_out=byte. char_out is stable while char_valid=1 and char_ready=0.
- Transfer rule: a transfer occurs on a cycle with char_valid & char_ready. On a transfer:
  - char_count+=1, cur_addr+=1.
  - If the new cur_addr>MEM_HI, set error and go to FINISH.
  - Else if char_count+1==MAX_LEN, set error and go to FINISH (abort).
  - Else if old cur_addr[1:0]==3, go to FETCH (word boundary).
  - Else stay in EMIT with the next byte from word_buf; back-to-back characters, one per cycle.
- FINISH: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- busy=1 in FETCH and EMIT only.
- Latency:
  - start sampled at edge N.
  - FETCH during cycle N+1.
  - First char_valid in cycle N+2.
  - A string of L chars with ready always high and a 4-aligned start: done in cycle N+2+L+ceil((L+1)/4)-1. The fetch of the terminator's word is included.
- mem_addr holds its last value outside FETCH; memory contents are not modified.
- char_ready while char_valid=0 has no effect.
- Reset mid-string aborts immediately: no done pulse, and char_count returns to 0.

Test Plan:
- Basic: memory word at 0x00400100 = 32'h00216948 ("Hi!\0"); start with start_addr=0x00400100. Required: chars 0x48, 0x69, 0x21 on consecutive cycles N+2..N+4; done at N+5; char_count=3; error=0.
- Unaligned plus boundary crossing: "ABCDEF\0" placed from 0x00400102; start at 0x00400102. Required: first char 'A' from bits [23:16]; one FETCH bubble after 'B' at the word boundary; 6 chars total; char_count=6.
- Backpressure: "Hi!" as in Basic, with char_ready low for 3 cycles on each char. Required: char_out holds each value while stalled; no duplicates or drops; busy stays high throughout; done once.
- Edge starts: start_addr=0 -> done at N+1, no char_valid, error=0. start_addr=0x00001000 -> done at N+1, error=1, no fetch.
- Runaway and overrun: MAX_LEN=8 over a nonzero-filled region -> exactly 8 chars, then done with error=1. A separate string running past MEM_HI -> abort with error=1.
- Reset and ignored start: assert reset after the 2nd char -> all outputs return to reset values asynchronously. Pulse start while busy -> ignored, the current string completes unchanged.

Source files
------------

// File: rtl/syscall_print_unit.sv
// Print-string syscall engine: walks a null-terminated byte string through a
// word-wide data-memory read port and streams characters to a valid/ready sink.
module syscall_print_unit #(
    parameter logic [31:0] MEM_LO  = 32'h0040_0000,
    parameter logic [31:0] MEM_HI  = 32'h0042_0000,
    parameter int unsigned MAX_LEN = 4096,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [31:0]       i_start_addr,
    output logic [31:0]       o_mem_addr,
    input  logic [31:0]       i_mem_read_data,
    output logic [7:0]        o_char_out,
    output logic              o_char_valid,
    input  logic              i_char_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [CNT_W-1:0]  o_char_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EMIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_cur_addr;
    logic [31:0]       w_cur_addr_nxt;
    logic [31:0]       r_word_buf;
    logic [31:0]       w_word_buf_nxt;
    logic [31:0]       w_mem_addr_nxt;
    logic [7:0]        w_char_nxt;
    logic              w_valid_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_error_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  w_count_inc;
    logic [31:0]       w_addr_inc;
    logic [7:0]        w_fetch_byte;
    logic [7:0]        w_next_byte;
    logic              w_xfer;
    logic              w_out_of_range;

    function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] ofs);
        logic [7:0] b;
        case (ofs)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    assign w_xfer         = (r_state == S_EMIT) && o_char_valid && i_char_ready;
    assign w_addr_inc     = r_cur_addr + 32'd1;
    assign w_count_inc    = o_char_count + CNT_W'(1);
    assign w_fetch_byte   = sel_byte(i_mem_read_data, r_cur_addr[1:0]);
    assign w_next_byte    = sel_byte(r_word_buf, w_addr_inc[1:0]);
    assign w_out_of_range = (i_start_addr < MEM_LO) || (i_start_addr > MEM_HI);

    // Next-state and next-output logic; a zero byte is detected as it is loaded,
    // so the terminator never occupies an EMIT cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_cur_addr_nxt = r_cur_addr;
        w_word_buf_nxt = r_word_buf;
        w_mem_addr_nxt = o_mem_addr;
        w_char_nxt     = o_char_out;
        w_valid_nxt    = o_char_valid;
        w_busy_nxt     = o_busy;
        w_done_nxt     = 1'b0;
        w_error_nxt    = o_error;
        w_count_nxt    = o_char_count;

        case (r_state)
            S_IDLE: begin
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                if (i_start) begin
                    w_cur_addr_nxt = i_start_addr;
                    w_count_nxt    = '0;
                    w_error_nxt    = 1'b0;
                    if (i_start_addr == 32'd0) begin
                        w_state_nxt = S_FINISH;
                        w_done_nxt  = 1'b1;
                    end else if (w_out_of_range) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = S_FINISH;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt    = S_FETCH;
                        w_busy_nxt     = 1'b1;
                        w_mem_addr_nxt = {i_start_addr[31:2], 2'b00};
                    end
                end
            end

            S_FETCH: begin
                w_word_buf_nxt = i_mem_read_data;
                if (w_fetch_byte == 8'h00) begin
                    w_state_nxt = S_FINISH;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_EMIT;
                    w_char_nxt  = w_fetch_byte;
                    w_valid_nxt = 1'b1;
                end
            end

            S_EMIT: begin
                if (w_xfer) begin
                    w_count_nxt    = w_count_inc;
                    w_cur_addr_nxt = w_addr_inc;
                    if ((w_addr_inc > MEM_HI) || (32'(w_count_inc) == 32'(MAX_LEN))) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = S_FINISH;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_valid_nxt = 1'b0;
                    end else if (r_cur_addr[1:0] == 2'd3) begin
                        w_state_nxt    = S_FETCH;
                        w_valid_nxt    = 1'b0;
                        w_mem_addr_nxt = {w_addr_inc[31:2], 2'b00};
                    end else if (w_next_byte == 8'h00) begin
                        w_state_nxt = S_FINISH;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_char_nxt = w_next_byte;
                    end
                end
            end

            S_FINISH: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_valid_nxt = 1'b0;
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cur_addr   <= '0;
            r_word_buf   <= '0;
            o_mem_addr   <= '0;
            o_char_out   <= '0;
            o_char_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_char_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_addr   <= w_cur_addr_nxt;
            r_word_buf   <= w_word_buf_nxt;
            o_mem_addr   <= w_mem_addr_nxt;
            o_char_out   <= w_char_nxt;
            o_char_valid <= w_valid_nxt;
            o_busy       <= w_busy_nxt;
            o_done       <= w_done_nxt;
            o_error      <= w_error_nxt;
            o_char_count <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_syscall_print_unit.sv
// Directed bench for syscall_print_unit: byte-addressed memory model, expected
// characters queued per request and compared as the sink accepts them.
module tb_syscall_print_unit;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned MAX_LEN = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      start_addr;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_rd;
    logic [7:0]       char_out;
    logic             char_valid;
    logic             char_ready;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] char_count;

    syscall_print_unit #(
        .MEM_LO (32'h0040_0000),
        .MEM_HI (32'h0042_0000),
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_start_addr   (start_addr),
        .o_mem_addr     (mem_addr),
        .i_mem_read_data(mem_rd),
        .o_char_out     (char_out),
        .o_char_valid   (char_valid),
        .i_char_ready   (char_ready),
        .o_busy         (busy),
        .o_done         (done),
        .o_error        (error),
        .o_char_count   (char_count)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [logic [31:0]];
    int         mem_gen = 0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ba;
            ba = {a[31:2], 2'b00} + 32'(i);
            w[8*i +: 8] = mem.exists(ba) ? mem[ba] : 8'h00;
        end
        return w;
    endfunction

    always @(mem_addr or mem_gen) mem_rd = rd_word(mem_addr);

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc_n   = 0;
    int         start_edge = 0;
    int         n_xfer, n_valid, n_fetch, n_done;
    int         done_rel, first_rel, last_rel;
    int         wait_cnt;
    int         inject_rel = 0;
    logic [31:0] inject_addr;
    bit         stall_mode = 1'b0;
    bit         prev_stall;
    logic [7:0] prev_char;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_str(input logic [31:0] a, input string s, input bit term);
        for (int i = 0; i < s.len(); i++) mem[a + 32'(i)] = s[i];
        if (term) mem[a + 32'(s.len())] = 8'h00;
        mem_gen++;
    endtask

    task automatic push_exp(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // One clock: drive sink/inject inputs, sample outputs, then advance to #1 past the edge.
    task automatic step();
        int rel;
        logic [7:0] e;
        rel = cyc_n - start_edge + 1;
        if (stall_mode) char_ready = char_valid && (wait_cnt >= 3);
        if (inject_rel > 0) begin
            start = (rel == inject_rel);
            if (rel == inject_rel) start_addr = inject_addr;
        end
        if (char_valid) begin
            n_valid++;
            if (first_rel < 0) first_rel = rel;
            chk("busy_while_valid", 32'(busy), 32'd1);
            if (prev_stall) chk("hold_char", 32'(char_out), 32'(prev_char));
            if (char_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                chk("char", 32'(char_out), 32'(e));
                n_xfer++;
                last_rel   = rel;
                wait_cnt   = 0;
                prev_stall = 1'b0;
            end else begin
                wait_cnt++;
                prev_stall = 1'b1;
                prev_char  = char_out;
            end
        end else begin
            prev_stall = 1'b0;
        end
        if (busy && !char_valid) n_fetch++;
        if (done) begin
            n_done++;
            done_rel = rel;
            chk("busy_at_done", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic launch(input logic [31:0] addr, input bit stall);
        n_xfer = 0; n_valid = 0; n_fetch = 0; n_done = 0;
        done_rel = -1; first_rel = -1; last_rel = -1;
        wait_cnt = 0; prev_stall = 1'b0; inject_rel = 0;
        stall_mode = stall;
        char_ready = !stall;
        start = 1'b1;
        start_addr = addr;
        @(posedge clk);
        #1;
        cyc_n++;
        start_edge = cyc_n;
        start = 1'b0;
    endtask

    task automatic run_string(input logic [31:0] addr, input bit stall,
                              input int inj_rel, input logic [31:0] inj_addr);
        int k;
        launch(addr, stall);
        inject_rel  = inj_rel;
        inject_addr = inj_addr;
        k = 0;
        while (n_done == 0 && k < 200) begin
            step();
            k++;
        end
        step();
        step();
        inject_rel = 0;
        start = 1'b0;
        chk("done_once", 32'(n_done), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_addr = '0; char_ready = 1'b1;
        load_str(32'h0040_0100, "Hi!", 1'b1);
        load_str(32'h0040_0200, "abcdefghijklmnop", 1'b0);
        load_str(32'h0041_FFFD, "WXYZ!", 1'b0);
        #1;
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_char_out", 32'(char_out), 32'd0);
        chk("rst_valid", 32'(char_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_count", 32'(char_count), 32'd0);
        @(posedge clk); #1; cyc_n++;
        @(posedge clk); #1; cyc_n++;
        reset = 1'b0;
        @(posedge clk); #1; cyc_n++;

        // Basic aligned string.
        push_exp("Hi!");
        run_string(32'h0040_0100, 1'b0, 0, 32'd0);
        chk("basic_first", 32'(first_rel), 32'd2);
        chk("basic_last", 32'(last_rel), 32'd4);
        chk("basic_done", 32'(done_rel), 32'd5);
        chk("basic_xfer", 32'(n_xfer), 32'd3);
        chk("basic_fetch", 32'(n_fetch), 32'd1);
        chk("basic_count", 32'(char_count), 32'd3);
        chk("basic_error", 32'(error), 32'd0);

        // Unaligned start crossing a word boundary.
        load_str(32'h0040_0102, "ABCDEF", 1'b1);
        push_exp("ABCDEF");
        run_string(32'h0040_0102, 1'b0, 0, 32'd0);
        chk("unal_first", 32'(first_rel), 32'd2);
        chk("unal_done", 32'(done_rel), 32'd10);
        chk("unal_fetch", 32'(n_fetch), 32'd3);
        chk("unal_count", 32'(char_count), 32'd6);
        chk("unal_error", 32'(error), 32'd0);

        // Backpressure: three stalled cycles per character.
        load_str(32'h0040_0100, "Hi!", 1'b1);
        push_exp("Hi!");
        run_string(32'h0040_0100, 1'b1, 0, 32'd0);
        chk("bp_first", 32'(first_rel), 32'd2);
        chk("bp_last", 32'(last_rel), 32'd13);
        chk("bp_done", 32'(done_rel), 32'd14);
        chk("bp_xfer", 32'(n_xfer), 32'd3);
        chk("bp_count", 32'(char_count), 32'd3);

        // Null pointer prints nothing.
        run_string(32'd0, 1'b0, 0, 32'd0);
        chk("null_done", 32'(done_rel), 32'd1);
        chk("null_valid", 32'(n_valid), 32'd0);
        chk("null_fetch", 32'(n_fetch), 32'd0);
        chk("null_error", 32'(error), 32'd0);
        chk("null_count", 32'(char_count), 32'd0);

        // Out-of-range pointer faults without fetching.
        run_string(32'h0000_1000, 1'b0, 0, 32'd0);
        chk("bad_done", 32'(done_rel), 32'd1);
        chk("bad_valid", 32'(n_valid), 32'd0);
        chk("bad_fetch", 32'(n_fetch), 32'd0);
        chk("bad_error", 32'(error), 32'd1);

        // Runaway string capped at MAX_LEN (also clears the previous error).
        push_exp("abcdefgh");
        run_string(32'h0040_0200, 1'b0, 0, 32'd0);
        chk("run_done", 32'(done_rel), 32'd11);
        chk("run_xfer", 32'(n_xfer), 32'd8);
        chk("run_fetch", 32'(n_fetch), 32'd2);
        chk("run_count", 32'(char_count), 32'd8);
        chk("run_error", 32'(error), 32'd1);

        // String running past the top of memory.
        push_exp("WXYZ");
        run_string(32'h0041_FFFD, 1'b0, 0, 32'd0);
        chk("ovr_done", 32'(done_rel), 32'd7);
        chk("ovr_xfer", 32'(n_xfer), 32'd4);
        chk("ovr_count", 32'(char_count), 32'd4);
        chk("ovr_error", 32'(error), 32'd1);

        // Start pulsed while busy is ignored.
        push_exp("Hi!");
        run_string(32'h0040_0100, 1'b0, 3, 32'h0040_0200);
        chk("inj_done", 32'(done_rel), 32'd5);
        chk("inj_xfer", 32'(n_xfer), 32'd3);
        chk("inj_count", 32'(char_count), 32'd3);
        chk("inj_error", 32'(error), 32'd0);

        // Reset in the middle of a string.
        push_exp("ab");
        launch(32'h0040_0200, 1'b0);
        for (int k = 0; k < 50 && n_xfer < 2; k++) step();
        chk("mid_xfer", 32'(n_xfer), 32'd2);
        chk("mid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_mem_addr", mem_addr, 32'd0);
        chk("mid_char_out", 32'(char_out), 32'd0);
        chk("mid_valid", 32'(char_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_error", 32'(error), 32'd0);
        chk("mid_count", 32'(char_count), 32'd0);
        @(posedge clk); #1; cyc_n++;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("mid_no_done", 32'(n_done), 32'd0);
        chk("mid_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
